// File: rtl/hash_pkg.sv
// Shared types for the hash control unit and its byte feeder.
package hash_pkg;
    localparam int HASH_BYTE_W = 8;

    typedef logic [HASH_BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        FD_IDLE  = 2'd0,
        FD_FILL  = 2'd1,
        FD_DRAIN = 2'd2,
        FD_EOF   = 2'd3
    } feeder_state_t;
endpackage

// File: rtl/hash_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and registered head.
module hash_byte_fifo
    import hash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [HASH_BYTE_W-1:0] din,
    output logic [HASH_BYTE_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count
);
    localparam logic [AW:0] PTR_ONE = 1;

    byte_t       mem_q [DEPTH];
    byte_t       mem_d [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr) begin
            mem_d  = '{default: '0};
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q[AW-1:0]] = din;
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
    end

    assign dout  = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
    assign count = wptr_q - rptr_q;
endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers host message bytes for the hash core and flags end of message.
module hash_msg_feeder
    import hash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       M,
    output logic             F_dr,
    input  logic             F_rtr,
    output logic             End_of_File,
    output logic [LEN_W-1:0] msg_len,
    output logic             err_proto
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      CNT_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    feeder_state_t    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             eof_q, eof_d;

    logic        clr, push, pop;
    logic        full, empty;
    logic [AW:0] count;

    hash_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .clr  (clr),
        .push (push),
        .pop  (pop),
        .din  (in_data),
        .dout (M),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign clr      = rst | start;
    assign in_ready = !full &&
                      (state_q == FD_IDLE || state_q == FD_FILL);
    assign push     = in_valid & in_ready & !clr;
    assign pop      = !empty & F_rtr & !clr;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            FD_IDLE: begin
                if (push) state_d = in_last ? FD_DRAIN : FD_FILL;
            end
            FD_FILL: begin
                if (push && in_last) state_d = FD_DRAIN;
            end
            FD_DRAIN: begin
                // Final pop empties the FIFO; EOF follows with F_dr already low
                if (pop && count == CNT_ONE) state_d = FD_EOF;
                if (in_valid) err_d = 1'b1;
            end
            FD_EOF: begin
                if (in_valid) err_d = 1'b1;
            end
        endcase
        if (pop && len_q != '1) len_d = len_q + LEN_ONE;
        if (clr) begin
            state_d = FD_IDLE;
            len_d   = '0;
            err_d   = 1'b0;
        end
        eof_d = (state_d == FD_EOF);
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        len_q   <= len_d;
        err_q   <= err_d;
        eof_q   <= eof_d;
    end

    assign F_dr        = !empty;
    assign End_of_File = eof_q;
    assign msg_len     = len_q;
    assign err_proto   = err_q;
endmodule
